// File: rtl/fetch_sequencer_if.sv
// Bundle between control decoder, fetch sequencer and instruction ROM.
// The master drives decode/condition inputs; the slave owns PC and status.
interface fetch_sequencer_if #(
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
);
    logic             Start;
    logic             Stall;
    logic             Halt;
    logic             BranchEn;
    logic             Taken;
    logic             BranchRel;
    logic [7:0]       Offset;
    logic [PC_W-1:0]  Target;
    logic [PC_W-1:0]  PC;
    logic             FetchValid;
    logic             Flush;
    logic             Done;
    logic [CNT_W-1:0] CycleCnt;
    logic [CNT_W-1:0] InstCnt;

    modport master (
        output Start, Stall, Halt, BranchEn, Taken,
        output BranchRel, Offset, Target,
        input  PC, FetchValid, Flush, Done,
        input  CycleCnt, InstCnt
    );

    modport slave (
        input  Start, Stall, Halt, BranchEn, Taken,
        input  BranchRel, Offset, Target,
        output PC, FetchValid, Flush, Done,
        output CycleCnt, InstCnt
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Program counter and run/halt sequencer for the 9-bit-instruction core.
// Taken branches cost one FLUSH cycle; counters saturate.
module fetch_sequencer #(
    parameter int PC_W       = 10,
    parameter int START_ADDR = 0,
    parameter int CNT_W      = 16
) (
    input  logic             CLK,
    input  logic             Reset,
    fetch_sequencer_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

    logic [1:0]       state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] inst_q, inst_d;
    logic [PC_W-1:0]  off_ext;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign off_ext = PC_W'($signed(bus.Offset));

    // Next-state, PC and counter selection by state and priority.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cyc_d   = cyc_q;
        inst_d  = inst_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.Start) begin
                    state_d = S_RUN;
                    pc_d    = START_PC;
                    cyc_d   = '0;
                    inst_d  = '0;
                end
            end
            S_RUN: begin
                cyc_d = sat_inc(cyc_q);
                if (bus.Stall) begin
                    pc_d = pc_q;
                end else if (bus.Halt) begin
                    inst_d  = sat_inc(inst_q);
                    state_d = S_DONE;
                end else if (bus.BranchEn && bus.Taken) begin
                    pc_d    = bus.BranchRel ? pc_q + off_ext : bus.Target;
                    inst_d  = sat_inc(inst_q);
                    state_d = S_FLUSH;
                end else begin
                    pc_d   = pc_q + PC_W'(1);
                    inst_d = sat_inc(inst_q);
                end
            end
            S_FLUSH: begin
                cyc_d = sat_inc(cyc_q);
                if (!bus.Stall) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset that overrides everything.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= S_IDLE;
            pc_q    <= START_PC;
            cyc_q   <= '0;
            inst_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cyc_q   <= cyc_d;
            inst_q  <= inst_d;
        end
    end

    assign bus.PC         = pc_q;
    assign bus.FetchValid = (state_q == S_RUN) || (state_q == S_FLUSH);
    assign bus.Flush      = (state_q == S_FLUSH);
    assign bus.Done       = (state_q == S_DONE);
    assign bus.CycleCnt   = cyc_q;
    assign bus.InstCnt    = inst_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with hand-computed expectations.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_fetch_sequencer;
    logic CLK;
    logic Reset;
    int   n_chk;
    int   n_pass;

    fetch_sequencer_if #(.PC_W(10), .CNT_W(16)) bus ();

    fetch_sequencer #(
        .PC_W(10),
        .START_ADDR(0),
        .CNT_W(16)
    ) dut (
        .CLK  (CLK),
        .Reset(Reset),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_st(input string tag, input int pc, input bit fv,
                          input bit fl, input bit dn);
        chk({tag, ".pc"}, 32'(bus.PC), pc);
        chk({tag, ".fv"}, 32'(bus.FetchValid), 32'(fv));
        chk({tag, ".flush"}, 32'(bus.Flush), 32'(fl));
        chk({tag, ".done"}, 32'(bus.Done), 32'(dn));
    endtask

    task automatic chk_cnt(input string tag, input int inst, input int cyc);
        chk({tag, ".inst"}, 32'(bus.InstCnt), inst);
        chk({tag, ".cyc"}, 32'(bus.CycleCnt), cyc);
    endtask

    task automatic clr();
        bus.Start     = 1'b0;
        bus.Stall     = 1'b0;
        bus.Halt      = 1'b0;
        bus.BranchEn  = 1'b0;
        bus.Taken     = 1'b0;
        bus.BranchRel = 1'b0;
        bus.Offset    = 8'h00;
        bus.Target    = 10'd0;
    endtask

    task automatic br_abs(input int tgt);
        bus.BranchEn  = 1'b1;
        bus.Taken     = 1'b1;
        bus.BranchRel = 1'b0;
        bus.Target    = 10'(tgt);
        step();
        clr();
    endtask

    task automatic br_rel(input logic [7:0] off);
        bus.BranchEn  = 1'b1;
        bus.Taken     = 1'b1;
        bus.BranchRel = 1'b1;
        bus.Offset    = off;
        step();
        clr();
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        clr();
        Reset = 1'b1;
        step();
        step();
        Reset = 1'b0;
        chk_st("rst", 0, 0, 0, 0);
        chk_cnt("rst", 0, 0);
        step();
        chk_st("idle", 0, 0, 0, 0);

        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("seq%0d.pc", i), 32'(bus.PC), i);
            chk($sformatf("seq%0d.fv", i), 32'(bus.FetchValid), 1);
            step();
        end
        chk_cnt("seq5", 5, 5);

        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
        chk_st("start_run", 6, 1, 0, 0);
        for (int i = 0; i < 14; i++) step();
        chk_cnt("pc20", 20, 20);

        br_rel(8'hFC);
        chk_st("rel-4", 16, 1, 1, 0);
        chk_cnt("rel-4", 21, 21);
        bus.Halt     = 1'b1;
        bus.BranchEn = 1'b1;
        bus.Taken    = 1'b1;
        step();
        clr();
        chk_st("flush_ign", 16, 1, 0, 0);
        step();
        chk_st("after_tgt", 17, 1, 0, 0);
        chk_cnt("after_tgt", 22, 23);

        br_abs(9);
        step();
        chk_st("at9", 9, 1, 0, 0);
        bus.BranchEn = 1'b1;
        bus.Taken    = 1'b0;
        step();
        clr();
        chk_st("nt", 10, 1, 0, 0);
        br_abs(300);
        chk_st("abs300", 300, 1, 1, 0);
        step();

        br_abs(1022);
        step();
        step();
        chk_st("pc1023", 1023, 1, 0, 0);
        step();
        chk_st("wrap0", 0, 1, 0, 0);
        step();
        step();
        chk_st("pc2", 2, 1, 0, 0);
        br_rel(8'hFB);
        chk_st("rel-5", 1021, 1, 1, 0);
        step();
        bus.Stall = 1'b1;
        step();
        bus.Stall = 1'b0;
        chk_st("stall_run", 1021, 1, 0, 0);
        chk_cnt("stall_run", 31, 37);

        br_abs(7);
        bus.Stall = 1'b1;
        step();
        chk_st("stall_flush", 7, 1, 1, 0);
        bus.Stall = 1'b0;
        step();
        chk_st("pc7", 7, 1, 0, 0);
        bus.Halt  = 1'b1;
        bus.Stall = 1'b1;
        step();
        chk_st("halt_st1", 7, 1, 0, 0);
        step();
        chk_st("halt_st2", 7, 1, 0, 0);
        bus.Stall = 1'b0;
        step();
        bus.Halt = 1'b0;
        chk_st("done", 7, 0, 0, 1);
        chk_cnt("done", 33, 43);
        step();
        chk_st("done_hold", 7, 0, 0, 1);
        chk_cnt("done_hold", 33, 43);

        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
        chk_st("restart", 0, 1, 0, 0);
        chk_cnt("restart", 0, 0);

        step();
        step();
        step();
        bus.Halt      = 1'b1;
        bus.BranchEn  = 1'b1;
        bus.Taken     = 1'b1;
        bus.Target    = 10'd300;
        step();
        clr();
        chk_st("halt_br", 3, 0, 0, 1);
        chk_cnt("halt_br", 4, 4);

        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
        br_abs(50);
        chk_st("pre_rst", 50, 1, 1, 0);
        Reset = 1'b1;
        step();
        chk_st("rst_flush", 0, 0, 0, 0);
        chk_cnt("rst_flush", 0, 0);
        bus.Start = 1'b1;
        step();
        Reset     = 1'b0;
        bus.Start = 1'b0;
        chk_st("rst_start", 0, 0, 0, 0);
        step();
        chk_st("idle_after", 0, 0, 0, 0);
        chk_cnt("idle_after", 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Owns the program counter and run/halt sequencing for the 9-bit-instruction core.
- Consumes the decoder's branch enable and the ALU condition flag, and produces the instruction ROM address, a fetch-valid qualifier, a one-cycle flush after taken branches, and Done.
- Sits between the control decoder and the instruction ROM, replacing the free-running PC.
- Keeps cycle and retired-instruction counters for the testbench and performance reporting.

Parameters:
- PC_W, 10, program counter width in bits; the ROM depth is 2^PC_W.
- START_ADDR, 0, PC value loaded on a Start.
- CNT_W, 16, width of CycleCnt and InstCnt.

Ports:
- CLK  input  1  system clock; all state updates on its rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  pulse that begins a program run; honoured only in IDLE or DONE.
- Stall  input  1  holds the PC and all state for the cycle.
- Halt  input  1  current instruction is a halt, decoded from the instruction.
- BranchEn  input  1  current instruction is a branch (from the control decoder).
- Taken  input  1  branch condition, the ALU ZERO flag.
- BranchRel  input  1  1 = relative branch (use Offset), 0 = absolute branch (use Target).
- Offset  input  8  signed two's-complement relative displacement.
- Target  input  PC_W  absolute branch target, from the branch LUT.
- PC  output  PC_W  instruction ROM address.
- FetchValid  output  1  PC addresses a live instruction this cycle.
- Flush  output  1  one-cycle bubble; the instruction fetched this cycle must be discarded.
- Done  output  1  program halted; level signal.
- CycleCnt  output  CNT_W  cycles spent in RUN or FLUSH since the last Start.
- InstCnt  output  CNT_W  instructions retired since the last Start.

Behaviour:

States are IDLE, RUN, FLUSH, DONE.

Reset, the highest priority and effective at the edge regardless of any other input:
- state = IDLE, PC = START_ADDR.
- FetchValid = 0, Flush = 0, Done = 0.
- CycleCnt = 0, InstCnt = 0.

Outputs by state, all registered or decoded from the state register only:
- FetchValid = 1 in RUN and FLUSH.
- Flush = 1 only in FLUSH.
- Done = 1 only in DONE.

IDLE:
- With Start: PC <= START_ADDR, counters <= 0, go to RUN.
- Otherwise hold.
- Stall, Halt and BranchEn are ignored.

RUN, evaluated in priority order each cycle:
1. Stall: hold PC, state and InstCnt; CycleCnt still increments.
2. Halt: PC holds, InstCnt +1, go to DONE.
3. BranchEn and Taken:
   - Absolute: PC <= Target.
   - Relative: PC <= PC + sign-extend(Offset) mod 2^PC_W.
   - InstCnt +1, go to FLUSH.
4. BranchEn and not Taken: PC <= PC+1, InstCnt +1, stay in RUN.
5. Otherwise: PC <= PC+1 mod 2^PC_W, InstCnt +1.

Start is ignored in RUN.

FLUSH:
- Lasts exactly one cycle when Stall is low. PC holds at the branch target, no instruction retires, then return to RUN.
- With Stall high: remain in FLUSH with Flush still asserted.
- Halt and BranchEn are ignored while in FLUSH; they refer to the discarded instruction.

DONE:
- PC, InstCnt and CycleCnt frozen; Done held high.
- Start: PC <= START_ADDR, counters <= 0, go to RUN; Done drops on the next cycle.

Timing:
- A branch resolved in cycle n drives PC = target at cycle n+1 with Flush = 1.
- The target instruction is valid at cycle n+2.
- Taken branch penalty: one cycle.

Arithmetic:
- PC wraps modulo 2^PC_W: PC+1 at 2^PC_W−1 gives 0.
- Relative offsets that cross 0 or 2^PC_W−1 wrap the same way.
- Counters saturate at 2^CNT_W−1; they do not wrap.
- CycleCnt counts every cycle spent in RUN or FLUSH, stalled or not.

Simultaneous events:
- Halt and BranchEn both high: Halt wins.
- Stall with anything else: Stall wins.
- Start together with Reset: Reset wins, state = IDLE.

Reset mid-run: returns to IDLE on the next edge with counters cleared; a further Start is needed to run.

Test Plan:
- Reset, then Start at t0, no branches, 5 cycles: PC = 0,1,2,3,4; FetchValid = 1; InstCnt = 5, CycleCnt = 5.
- PC = 20, BranchEn=1, Taken=1, BranchRel=1, Offset=−4: next PC = 16 with Flush=1 for one cycle; PC = 17 after the following instruction; one retire lost.
- PC = 1023 (PC_W=10) with sequential flow: PC → 0. Relative branch at PC = 2 with Offset=−5: PC = 1021.
- Halt at PC = 7 with Stall=1 for 2 cycles, then Stall=0: PC holds at 7 for 3 cycles, Done=1 afterwards. Restart with Start: PC = 0, counters = 0, Done = 0.
- BranchEn=1, Taken=0 at PC = 9: PC = 10, no Flush. BranchEn=1, Taken=1, BranchRel=0, Target=300: PC = 300, Flush=1. Halt and BranchEn together: DONE, PC unchanged.
- Reset asserted during FLUSH: IDLE next edge, Flush=0, PC = START_ADDR, CycleCnt = 0. Start in RUN ignored; Start together with Reset ignored.
